// File: rtl/write_arbiter_pkg.sv
// write_arbiter_pkg: shared FSM encoding and default parameters for the priority grant decoder
package write_arbiter_pkg;
   localparam int DEF_DATA_WIDTH = 256;
   localparam int DEF_NUM_PORTS  = 16;
   localparam int DEF_PRIO_WIDTH = 3;
   localparam int DEF_PRIO_LSB   = 4;
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/priority_grant_decoder_if.sv
// priority_grant_decoder_if: request bus and grant handshake between producers, decoder and consumer
interface priority_grant_decoder_if
   import write_arbiter_pkg::*;
#(
   parameter int ARBITER_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_OF_PORTS       = DEF_NUM_PORTS,
   parameter int PRIORITY_WIDTH     = DEF_PRIO_WIDTH,
   parameter int PORT_W             = $clog2(NUM_OF_PORTS)
);
   logic [ARBITER_DATA_WIDTH*NUM_OF_PORTS-1:0] priority_decoder_in;
   logic [NUM_OF_PORTS-1:0]                    ready;
   logic [NUM_OF_PORTS*PRIORITY_WIDTH-1:0]     priority_out;
   logic [NUM_OF_PORTS-1:0]                    pending_out;
   logic                                       grant_valid;
   logic [PORT_W-1:0]                          grant_port;
   logic [PRIORITY_WIDTH-1:0]                  grant_prio;
   logic                                       grant_accept;
   modport master (
      output priority_decoder_in, ready, grant_accept,
      input  priority_out, pending_out, grant_valid, grant_port, grant_prio
   );
   modport slave (
      input  priority_decoder_in, ready, grant_accept,
      output priority_out, pending_out, grant_valid, grant_port, grant_prio
   );
endinterface

// File: rtl/priority_grant_decoder_rr_max_select.sv
// rr_max_select: picks the highest-priority eligible port, ties resolved by rotation from rr_ptr
module rr_max_select #(
   parameter int NUM_OF_PORTS   = 16,
   parameter int PRIORITY_WIDTH = 3,
   parameter int PORT_W         = $clog2(NUM_OF_PORTS)
) (
   input  logic [NUM_OF_PORTS-1:0]                pending,
   input  logic [NUM_OF_PORTS*PRIORITY_WIDTH-1:0] priorities,
   input  logic [PORT_W-1:0]                      rr_ptr,
   input  logic [NUM_OF_PORTS-1:0]                mask,
   output logic [PORT_W-1:0]                      index,
   output logic [PRIORITY_WIDTH-1:0]              prio,
   output logic                                   any
);
   // walk ports in rotation order; strict > keeps the first tied port met after rr_ptr
   always_comb begin
      index = '0;
      prio  = '0;
      any   = 1'b0;
      for (int k = 0; k < NUM_OF_PORTS; k++) begin
         automatic int p = (int'(rr_ptr) + k) % NUM_OF_PORTS;
         if (pending[p] && mask[p] && (!any || priorities[p*PRIORITY_WIDTH +: PRIORITY_WIDTH] > prio)) begin
            any   = 1'b1;
            index = PORT_W'(p);
            prio  = priorities[p*PRIORITY_WIDTH +: PRIORITY_WIDTH];
         end
      end
   end
endmodule

// File: rtl/priority_grant_decoder.sv
// priority_grant_decoder: captures per-port priorities and issues one registered grant at a time
module priority_grant_decoder
   import write_arbiter_pkg::*;
#(
   parameter int ARBITER_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_OF_PORTS       = DEF_NUM_PORTS,
   parameter int PRIORITY_WIDTH     = DEF_PRIO_WIDTH,
   parameter int PRIORITY_LSB       = DEF_PRIO_LSB,
   parameter int PORT_W             = $clog2(NUM_OF_PORTS)
) (
   input logic clk,
   input logic rst_n,
   priority_grant_decoder_if.slave bus
);
   state_t                                 state, state_nx;
   logic [NUM_OF_PORTS-1:0]                pending, pending_nx, clr_v, set_v, mask;
   logic [NUM_OF_PORTS*PRIORITY_WIDTH-1:0] prio_r, prio_nx;
   logic [PORT_W-1:0]                      rr_ptr, rr_nx, gport, gport_nx, sel_idx, sel_rr;
   logic [PRIORITY_WIDTH-1:0]              gprio, gprio_nx, sel_prio;
   logic                                   gvalid, sel_any, accept;

   assign accept = (state == GRANT) && bus.grant_accept;
   assign sel_rr = accept ? (gport == PORT_W'(NUM_OF_PORTS-1) ? '0 : gport + 1'b1) : rr_ptr;
   assign clr_v  = accept ? NUM_OF_PORTS'(1) << gport : '0;
   assign mask   = ~clr_v;
   assign set_v  = bus.ready & (~pending | clr_v);
   assign pending_nx = (pending & ~clr_v) | set_v;

   rr_max_select #(
      .NUM_OF_PORTS  (NUM_OF_PORTS),
      .PRIORITY_WIDTH(PRIORITY_WIDTH),
      .PORT_W        (PORT_W)
   ) u_sel (
      .pending   (pending),
      .priorities(prio_r),
      .rr_ptr    (sel_rr),
      .mask      (mask),
      .index     (sel_idx),
      .prio      (sel_prio),
      .any       (sel_any)
   );

   // load a slot on capture, zero it when its grant is taken without a re-request
   always_comb begin
      prio_nx = prio_r;
      for (int j = 0; j < NUM_OF_PORTS; j++)
         prio_nx[j*PRIORITY_WIDTH +: PRIORITY_WIDTH] = set_v[j]
            ? bus.priority_decoder_in[j*ARBITER_DATA_WIDTH + PRIORITY_LSB +: PRIORITY_WIDTH]
            : (clr_v[j] ? '0 : prio_r[j*PRIORITY_WIDTH +: PRIORITY_WIDTH]);
   end

   // grant FSM: hold the offer until accepted, then chain the next selection on the same edge
   always_comb begin
      state_nx = state;
      gport_nx = gport;
      gprio_nx = gprio;
      rr_nx    = rr_ptr;
      if (state == IDLE) begin
         if (|pending) begin
            state_nx = GRANT;
            gport_nx = sel_idx;
            gprio_nx = sel_prio;
         end
      end else if (accept) begin
         rr_nx    = sel_rr;
         state_nx = sel_any ? GRANT : IDLE;
         gport_nx = sel_any ? sel_idx : gport;
         gprio_nx = sel_any ? sel_prio : gprio;
      end
   end

   // state and output registers, cleared immediately by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pending <= '0;
         prio_r  <= '0;
         rr_ptr  <= '0;
         gport   <= '0;
         gprio   <= '0;
         gvalid  <= 1'b0;
      end else begin
         state   <= state_nx;
         pending <= pending_nx;
         prio_r  <= prio_nx;
         rr_ptr  <= rr_nx;
         gport   <= gport_nx;
         gprio   <= gprio_nx;
         gvalid  <= (state_nx == GRANT);
      end
   end

   assign bus.priority_out = prio_r;
   assign bus.pending_out  = pending;
   assign bus.grant_valid  = gvalid;
   assign bus.grant_port   = gport;
   assign bus.grant_prio   = gprio;
endmodule

// File: tb/tb_priority_grant_decoder.sv
// tb_priority_grant_decoder: vector table plus grant-order scoreboard for the priority grant decoder
module tb_priority_grant_decoder;
   localparam int DW = 256, N = 16, PW = 3, PL = 4, PWD = 4;

   typedef struct {int port; int prio;} grant_t;
   typedef struct {int port; int prio; logic [15:0] exp_pending; logic [47:0] exp_po;} vec_t;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   int     checks = 0;
   int     errors = 0;
   grant_t exp_q[$];
   grant_t got;
   vec_t   tbl[6];

   always #5 clk = ~clk;

   priority_grant_decoder_if #(.ARBITER_DATA_WIDTH(DW), .NUM_OF_PORTS(N), .PRIORITY_WIDTH(PW), .PORT_W(PWD)) bus ();

   priority_grant_decoder #(
      .ARBITER_DATA_WIDTH(DW), .NUM_OF_PORTS(N), .PRIORITY_WIDTH(PW), .PRIORITY_LSB(PL), .PORT_W(PWD)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble();
      for (int i = 0; i < DW*N/32; i++) bus.priority_decoder_in[i*32 +: 32] = $urandom;
   endtask

   task automatic req(input int port, input int prio);
      bus.ready[port] = 1'b1;
      bus.priority_decoder_in[port*DW + PL +: PW] = PW'(prio);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.ready = '0;
      bus.grant_accept = 1'b0;
      tick();
      chk("rst_valid", 64'(bus.grant_valid), 0);
      chk("rst_pending", 64'(bus.pending_out), 0);
      chk("rst_prio_out", 64'(bus.priority_out), 0);
      chk("rst_gport", 64'(bus.grant_port), 0);
      chk("rst_gprio", 64'(bus.grant_prio), 0);
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((bus.grant_valid || bus.pending_out != 0) && n < 30) begin
         tick();
         n++;
      end
      chk({name, "_idle"}, {63'(bus.pending_out), bus.grant_valid}, 0);
      chk({name, "_drained"}, 64'(exp_q.size()), 0);
      bus.grant_accept = 1'b0;
      exp_q.delete();
   endtask

   // every accepted grant must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && bus.grant_valid && bus.grant_accept) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL grant_unexpected: port %0d prio %0d with nothing expected", bus.grant_port, bus.grant_prio);
         end else begin
            got = exp_q.pop_front();
            chk("sb_port", 64'(bus.grant_port), 64'(got.port));
            chk("sb_prio", 64'(bus.grant_prio), 64'(got.prio));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{0, 5, 16'h0001, 48'h5};
      tbl[1] = '{15, 7, 16'h8000, 48'hE000_0000_0000};
      tbl[2] = '{7, 3, 16'h0080, 48'h60_0000};
      tbl[3] = '{10, 0, 16'h0400, 48'h0};
      tbl[4] = '{4, 6, 16'h0010, 48'h6000};
      tbl[5] = '{13, 1, 16'h2000, 48'h80_0000_0000};
      bus.ready = '0;
      bus.grant_accept = 1'b0;
      bus.priority_decoder_in = '0;
      do_reset();

      foreach (tbl[i]) begin
         scramble();
         req(tbl[i].port, tbl[i].prio);
         tick();
         bus.ready = '0;
         chk("cap_pending", 64'(bus.pending_out), 64'(tbl[i].exp_pending));
         chk("cap_prio_out", 64'(bus.priority_out), 64'(tbl[i].exp_po));
         chk("cap_no_grant_yet", 64'(bus.grant_valid), 0);
         tick();
         chk("grant_valid", 64'(bus.grant_valid), 1);
         chk("grant_port", 64'(bus.grant_port), 64'(tbl[i].port));
         chk("grant_prio", 64'(bus.grant_prio), 64'(tbl[i].prio));
         exp_q.push_back('{tbl[i].port, tbl[i].prio});
         bus.grant_accept = 1'b1;
         tick();
         bus.grant_accept = 1'b0;
         chk("acc_valid", 64'(bus.grant_valid), 0);
         chk("acc_pending", 64'(bus.pending_out), 0);
         chk("acc_prio_out", 64'(bus.priority_out), 0);
      end

      do_reset();
      scramble();
      req(3, 2); req(7, 6); req(9, 6);
      tick();
      bus.ready = '0;
      exp_q.push_back('{7, 6}); exp_q.push_back('{9, 6}); exp_q.push_back('{3, 2});
      bus.grant_accept = 1'b1;
      wait_idle("prio_tie");

      do_reset();
      for (int r = 0; r < 2; r++) begin
         scramble();
         req(1, 4); req(5, 4); req(14, 4);
         tick();
         bus.ready = '0;
         exp_q.push_back('{1, 4}); exp_q.push_back('{5, 4}); exp_q.push_back('{14, 4});
         bus.grant_accept = 1'b1;
         wait_idle("rr_wrap");
      end

      do_reset();
      scramble();
      req(2, 3);
      tick();
      bus.ready = '0;
      tick();
      for (int c = 0; c < 4; c++) begin
         if (c == 0) req(6, 7);
         tick();
         bus.ready = '0;
         chk("hold_port", 64'(bus.grant_port), 2);
         chk("hold_prio", 64'(bus.grant_prio), 3);
      end
      chk("hold_pending", 64'(bus.pending_out), 64'h0044);
      exp_q.push_back('{2, 3}); exp_q.push_back('{6, 7});
      bus.grant_accept = 1'b1;
      wait_idle("no_preempt");

      do_reset();
      scramble();
      req(4, 1);
      tick();
      req(4, 6);
      tick();
      bus.ready = '0;
      chk("ignore_slot4", 64'(bus.priority_out[4*PW +: PW]), 1);
      chk("ignore_gport", 64'(bus.grant_port), 4);
      chk("ignore_gprio", 64'(bus.grant_prio), 1);
      exp_q.push_back('{4, 1}); exp_q.push_back('{4, 6});
      req(4, 6);
      bus.grant_accept = 1'b1;
      tick();
      bus.ready = '0;
      chk("recap_pending", 64'(bus.pending_out), 64'h0010);
      chk("recap_slot4", 64'(bus.priority_out[4*PW +: PW]), 6);
      chk("recap_not_same_edge", 64'(bus.grant_valid), 0);
      wait_idle("recapture");

      do_reset();
      scramble();
      req(2, 3); req(9, 5);
      tick();
      bus.ready = '0;
      tick();
      chk("pre_areset_port", 64'(bus.grant_port), 9);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("areset_valid", 64'(bus.grant_valid), 0);
      chk("areset_pending", 64'(bus.pending_out), 0);
      chk("areset_prio_out", 64'(bus.priority_out), 0);
      chk("areset_gport", 64'(bus.grant_port), 0);
      #1 rst_n = 1'b1;
      req(11, 2);
      tick();
      bus.ready = '0;
      chk("first_capture", 64'(bus.pending_out), 64'h0800);
      exp_q.push_back('{11, 2});
      bus.grant_accept = 1'b1;
      wait_idle("post_areset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
